// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES decrypt-datapath types, widths and byte-permutation helper
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  // Occupancy of a 2-entry elastic buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // InvShiftRows on a column-major state (byte i = s[127-8i -: 8]).
  // Output byte at (col c, row r) comes from input (col (c-r) mod 4, row r),
  // i.e. row r is rotated right by r positions.
  function automatic logic [AES_STATE_W-1:0] aes_inv_shift_rows(
    input logic [AES_STATE_W-1:0] s
  );
    logic [AES_STATE_W-1:0] res;
    int dst;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dst = 4 * c + r;
        src = 4 * ((c - r + 4) % 4) + r;
        res[AES_STATE_W-1-AES_BYTE_W*dst -: AES_BYTE_W] =
          s[AES_STATE_W-1-AES_BYTE_W*src -: AES_BYTE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// rtl/aes_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered handshake outputs
module aes_skid_buf
  import aes_pkg::*;
#(
  parameter int W = 133
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic         drain;

  // Next occupancy and entry contents; head is always the oldest entry
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    accept = in_valid & in_ready_q;
    drain  = out_valid_q & out_ready;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          head_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && !drain) begin
          tail_d = in_data;
          occ_d  = OCC_TWO;
        end else if (drain && !accept) begin
          occ_d = OCC_EMPTY;
        end else if (accept && drain) begin
          // Head leaves this cycle, so the new state replaces it directly
          head_d = in_data;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // Handshake outputs are decoded from the next occupancy and registered,
    // keeping out_ready->in_ready and in_valid->out_valid free of comb paths
    in_ready_d  = (occ_d != OCC_TWO);
    out_valid_d = (occ_d != OCC_EMPTY);
  end

  // State registers; reset drops any buffered entries and clears their contents
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/inv_shift_rows_stage.sv
// rtl/inv_shift_rows_stage.sv - AES InvShiftRows elastic pipeline stage for the decrypt round
module inv_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int SB_W         = 5,
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [SB_W-1:0]        in_sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic [SB_W-1:0]        out_sb
);

  localparam int BUF_W = AES_STATE_W + SB_W;

  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;
  logic             buf_valid;

  // Permute on the way in so the buffer only ever holds finished states
  always_comb begin
    buf_in = {aes_inv_shift_rows(in_state), in_sb};
  end

  aes_skid_buf #(
    .W(BUF_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(buf_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  // Optionally blank the outputs when idle so no stale key-dependent state is visible
  always_comb begin
    out_valid = buf_valid;
    out_state = buf_out[BUF_W-1 -: AES_STATE_W];
    out_sb    = buf_out[SB_W-1:0];
    if (ZERO_ON_IDLE && !buf_valid) begin
      out_state = '0;
      out_sb    = '0;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// tb/tb_inv_shift_rows_stage.sv - scoreboard bench for the InvShiftRows elastic stage
module tb_inv_shift_rows_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [4:0]   in_sb;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [4:0]   out_sb;

  typedef struct packed {
    logic [127:0] st;
    logic [4:0]   sb;
  } item_t;

  item_t        exp_q[$];
  item_t        mon_e;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_pop = 0;
  logic         prev_stall = 1'b0;
  logic         prev_valid = 1'b0;
  logic [127:0] prev_state = '0;
  logic [4:0]   prev_sb = '0;

  inv_shift_rows_stage #(
    .SB_W(5),
    .ZERO_ON_IDLE(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .in_sb    (in_sb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .out_sb   (out_sb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h expected %032h", nm, act, exp);
    end
  endtask

  // Forward ShiftRows: row r rotated left by r, column-major byte order
  function automatic logic [127:0] fwd_sr(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return res;
  endfunction

  // Present one state and hold it until accepted; expected item pushed on acceptance
  task automatic send(input logic [127:0] st, input logic [4:0] sb, input item_t e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_state = st;
    in_sb = sb;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Monitor: pops and compares on every output transfer, checks stall stability and idle blanking
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_state", out_state, prev_state);
        chk("stall_sb", out_sb, prev_sb);
      end
      if (prev_valid && !out_valid) chk("idle_zero", out_state, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %032h/%02h expected none", out_state, out_sb);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_state", out_state, mon_e.st);
          chk("out_sb", out_sb, mon_e.sb);
          n_pop++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_state = out_state;
      prev_sb = out_sb;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] orig;
    logic [4:0]   sb;
    logic         pending;
    logic         acc;
    int           start;
    int           sent;
    int           cyc;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = '0;
    in_sb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_state", out_state, 0);
    chk("rst_out_sb", out_sb, 0);
    reset = 1'b0;

    // Counting vector, 1-cycle latency
    out_ready = 1'b1;
    send(128'h000102030405060708090a0b0c0d0e0f, 5'h15,
         '{st: 128'h000d0a0704010e0b0805020f0c090603, sb: 5'h15});
    chk("latency_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Round trip through forward ShiftRows at full rate
    start = n_pop;
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      sb = 5'($urandom);
      in_valid = 1'b1;
      in_state = fwd_sr(orig);
      in_sb = sb;
      chk("rt_in_ready", in_ready, 1);
      exp_q.push_back('{st: orig, sb: sb});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rt_throughput", n_pop - start, 1000);

    // Backpressure: A then B fill the buffer, C is held off
    out_ready = 1'b0;
    send(128'h101112131415161718191a1b1c1d1e1f, 5'h01,
         '{st: 128'h101d1a1714111e1b1815121f1c191613, sb: 5'h01});
    send(128'h202122232425262728292a2b2c2d2e2f, 5'h02,
         '{st: 128'h202d2a2724212e2b2825222f2c292623, sb: 5'h02});
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_state, 128'h101d1a1714111e1b1815121f1c191613);
    in_valid = 1'b1;
    in_state = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    in_sb = 5'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_c_blocked", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_gap", out_valid, 1);
      if (in_valid && in_ready) begin
        exp_q.push_back('{st: 128'hf0fdfaf7f4f1fefbf8f5f2fffcf9f6f3, sb: 5'h03});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_c_accepted", acc, 1);
    @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);

    // Random in_valid / out_ready
    sent = 0;
    pending = 1'b0;
    cyc = 0;
    while (sent < 5000 && cyc < 40000) begin
      out_ready = 1'($urandom % 2);
      if (!pending && ($urandom % 2 == 1)) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        sb = 5'($urandom);
        in_state = fwd_sr(orig);
        in_sb = sb;
        in_valid = 1'b1;
        pending = 1'b1;
      end
      acc = 1'b0;
      @(negedge clk);
      if (pending && in_ready) begin
        exp_q.push_back('{st: orig, sb: sb});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        pending = 1'b0;
        in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", sent, 5000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drain", exp_q.size(), 0);

    // Reset while holding two entries
    out_ready = 1'b0;
    send(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, 5'h0a,
         '{st: 128'ha0adaaa7a4a1aeaba8a5a2afaca9a6a3, sb: 5'h0a});
    send(128'h202122232425262728292a2b2c2d2e2f, 5'h0b,
         '{st: 128'h202d2a2724212e2b2825222f2c292623, sb: 5'h0b});
    chk("two_in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_state", out_state, 0);
    chk("mid_rst_out_sb", out_sb, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    reset = 1'b0;
    out_ready = 1'b1;
    send(128'h303132333435363738393a3b3c3d3e3f, 5'h1f,
         '{st: 128'h303d3a3734313e3b3835323f3c393633, sb: 5'h1f});
    chk("post_rst_latency", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_drain", exp_q.size(), 0);
    chk("post_rst_idle_state", out_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
